// File: rtl/proc_pkg.sv
// Shared types and constants for the 12-bit simple processor control path.
package proc_pkg;

  // Datapath widths
  localparam int PROC_IADDR_W = 3;
  localparam int PROC_INSTR_W = 12;
  localparam int PROC_RADDR_W = 3;
  localparam int PROC_DADDR_W = 4;

  // Opcodes; the remaining encodings (010, 011, 100, 111) are undefined
  typedef enum logic [2:0] {
    OP_LOAD  = 3'b000,
    OP_STORE = 3'b001,
    OP_ADD   = 3'b101,
    OP_SUB   = 3'b110
  } opcode_t;

  // Sequencer states, one instruction per FETCH..WB pass
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB
  } state_t;

  // Instruction field positions
  localparam int OP_HI     = 11;
  localparam int OP_LO     = 9;
  localparam int ALU_WA_HI = 8;   // ALU destination register
  localparam int ALU_WA_LO = 6;
  localparam int MEM_R_HI  = 6;   // LOAD destination / STORE source register
  localparam int MEM_R_LO  = 4;
  localparam int RB_HI     = 5;   // second ALU operand
  localparam int RB_LO     = 3;
  localparam int RA_HI     = 2;   // first ALU operand
  localparam int RA_LO     = 0;
  localparam int DADDR_HI  = 3;   // data-memory word address
  localparam int DADDR_LO  = 0;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: IR -> register/memory addresses and op class.
// The field layout is fixed to the 12-bit encoding defined in proc_pkg.
module instr_decoder
  import proc_pkg::*;
(
  input  logic [PROC_INSTR_W-1:0] ir,
  output logic [PROC_RADDR_W-1:0] ra1,
  output logic [PROC_RADDR_W-1:0] ra2,
  output logic [PROC_RADDR_W-1:0] wa,
  output logic [PROC_DADDR_W-1:0] dmem_addr,
  output logic                    is_load,
  output logic                    is_store,
  output logic                    is_alu,
  output logic                    alu_sub,
  output logic                    illegal
);

  logic [2:0] op;
  assign op = ir[OP_HI:OP_LO];

  // Classify the opcode and pick the register fields that class uses
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_alu   = 1'b0;
    alu_sub  = 1'b0;
    illegal  = 1'b0;
    case (op)
      OP_LOAD:  is_load  = 1'b1;
      OP_STORE: is_store = 1'b1;
      OP_ADD:   is_alu   = 1'b1;
      OP_SUB: begin
        is_alu  = 1'b1;
        alu_sub = 1'b1;
      end
      default:  illegal  = 1'b1;
    endcase
    // ALU ops use the low/high operand fields; memory ops share the [6:4] register field
    ra1       = is_alu ? ir[RA_HI:RA_LO] : ir[MEM_R_HI:MEM_R_LO];
    ra2       = ir[RB_HI:RB_LO];
    wa        = is_alu ? ir[ALU_WA_HI:ALU_WA_LO] : ir[MEM_R_HI:MEM_R_LO];
    dmem_addr = ir[DADDR_HI:DADDR_LO];
  end

endmodule

// File: rtl/proc_control_unit.sv
// Multicycle sequencer: owns PC and IR, runs FETCH/DECODE/EXEC/WB per instruction
// and drives regfile, ALU and data-memory strobes as decodes of state and IR.
module proc_control_unit
  import proc_pkg::*;
#(
  parameter int IADDR_W = PROC_IADDR_W,
  parameter int INSTR_W = PROC_INSTR_W,
  parameter int RADDR_W = PROC_RADDR_W,
  parameter int DADDR_W = PROC_DADDR_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               step_mode,
  output logic [IADDR_W-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [RADDR_W-1:0] rf_ra1,
  output logic [RADDR_W-1:0] rf_ra2,
  output logic [RADDR_W-1:0] rf_wa,
  output logic               rf_we,
  output logic               rf_wsel,
  output logic               alu_sub,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic               dmem_we,
  output logic               busy,
  output logic               done,
  output logic               illegal,
  output logic [IADDR_W-1:0] pc
);

  state_t               state_reg, state_next;
  logic [IADDR_W-1:0]   pc_reg, pc_next;
  logic [INSTR_W-1:0]   ir_reg, ir_next;
  logic                 step_reg, step_next;

  logic dec_load, dec_store, dec_alu, dec_illegal;

  instr_decoder u_dec (
    .ir        (ir_reg),
    .ra1       (rf_ra1),
    .ra2       (rf_ra2),
    .wa        (rf_wa),
    .dmem_addr (dmem_addr),
    .is_load   (dec_load),
    .is_store  (dec_store),
    .is_alu    (dec_alu),
    .alu_sub   (alu_sub),
    .illegal   (dec_illegal)
  );

  // ALU result feeds the regfile for ADD/SUB, data memory for LOAD
  assign rf_wsel   = dec_alu;
  assign imem_addr = pc_reg;
  assign pc        = pc_reg;
  assign busy      = (state_reg != ST_IDLE);

  // State, PC, IR and step latch; async reset drops any pending strobe at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      pc_reg    <= '0;
      ir_reg    <= '0;
      step_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
      step_reg  <= step_next;
    end
  end

  // Next-state sequencing and strobe decode
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    step_next  = step_reg;
    rf_we      = 1'b0;
    dmem_we    = 1'b0;
    done       = 1'b0;
    illegal    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // start is only honoured here, so a pulse while busy has no effect
        if (start) begin
          step_next  = step_mode;
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        ir_next    = imem_data;
        state_next = ST_DECODE;
      end
      ST_DECODE: begin
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        dmem_we    = dec_store;
        illegal    = dec_illegal;
        state_next = ST_WB;
      end
      ST_WB: begin
        rf_we   = dec_load | dec_alu;
        pc_next = pc_reg + 1'b1;
        // Stop after one instruction in step mode, or once the PC wraps
        if (step_reg || (pc_reg == {IADDR_W{1'b1}})) begin
          done       = 1'b1;
          state_next = ST_IDLE;
        end else begin
          state_next = ST_FETCH;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_proc_control_unit.sv
// Directed self-checking bench for proc_control_unit with a behavioural datapath
// (instruction memory, register file, ALU, data memory) around it.
module tb_proc_control_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        step_mode;
  logic [2:0]  imem_addr;
  logic [11:0] imem_data;
  logic [2:0]  rf_ra1, rf_ra2, rf_wa;
  logic        rf_we, rf_wsel, alu_sub;
  logic [3:0]  dmem_addr;
  logic        dmem_we, busy, done, illegal;
  logic [2:0]  pc;

  int tests = 0;
  int fails = 0;

  // Per-run observations, written only by the main initial block
  int run_cyc, n_we, n_dm, n_ill, n_done, n_both, ill_cyc;
  logic [2:0] last_wa;
  logic       last_wsel, last_sub;
  logic [3:0] last_daddr;

  logic [11:0] imem [8];
  logic [11:0] rf   [8]  = '{default: 12'd0};
  logic [11:0] dmem [16] = '{0: 12'd6, 1: 12'd2, default: 12'd0};

  always #5 clk = ~clk;

  assign imem_data = imem[imem_addr];

  // Datapath model: regfile and data memory update on the rising edge
  always @(posedge clk) begin
    if (rf_we)
      rf[rf_wa] <= rf_wsel ? (alu_sub ? rf[rf_ra1] - rf[rf_ra2] : rf[rf_ra1] + rf[rf_ra2])
                           : dmem[dmem_addr];
    if (dmem_we)
      dmem[dmem_addr] <= rf[rf_ra1];
  end

  proc_control_unit dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .step_mode (step_mode),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .rf_ra1    (rf_ra1),
    .rf_ra2    (rf_ra2),
    .rf_wa     (rf_wa),
    .rf_we     (rf_we),
    .rf_wsel   (rf_wsel),
    .alu_sub   (alu_sub),
    .dmem_addr (dmem_addr),
    .dmem_we   (dmem_we),
    .busy      (busy),
    .done      (done),
    .illegal   (illegal),
    .pc        (pc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue start, then watch strobes at each falling edge until done (bounded).
  // poke = cycle index at which a stray start pulse is driven (-1 for none).
  task automatic run(input logic sm, input int poke);
    n_we = 0; n_dm = 0; n_ill = 0; n_done = 0; n_both = 0; ill_cyc = -1; run_cyc = -1;
    last_wa = '0; last_wsel = 1'b0; last_sub = 1'b0; last_daddr = '0;
    @(negedge clk);
    step_mode = sm;
    start     = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      start     = (c == poke);
      step_mode = 1'b0;
      if (rf_we) begin
        n_we++;
        last_wa   = rf_wa;
        last_wsel = rf_wsel;
        last_sub  = alu_sub;
      end
      if (dmem_we) begin
        n_dm++;
        last_daddr = dmem_addr;
      end
      if (rf_we && dmem_we) n_both++;
      if (illegal) begin
        n_ill++;
        ill_cyc = c;
      end
      if (done) begin
        n_done++;
        run_cyc = c;
        break;
      end
    end
    start = 1'b0;
    @(negedge clk);
    $display("[TB] run step_mode=%0d cycles=%0d rf_we=%0d dmem_we=%0d illegal=%0d pc=%0d",
             sm, run_cyc, n_we, n_dm, n_ill, pc);
    check("done_cleared", 32'(done), 32'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b1;
    step_mode = 1'b0;
    // Standard program
    imem[0] = 12'b000_00_000_0000;  // LOAD  r0 <= d[0]
    imem[1] = 12'b000_00_001_0001;  // LOAD  r1 <= d[1]
    imem[2] = 12'b101_010_001_000;  // ADD   r2 <= r0 + r1
    imem[3] = 12'b101_011_001_010;  // ADD   r3 <= r2 + r1
    imem[4] = 12'b110_100_001_000;  // SUB   r4 <= r0 - r1
    imem[5] = 12'b001_00_100_0101;  // STORE d[5] <= r4
    imem[6] = 12'b000_00_110_0001;  // LOAD  r6 <= d[1]
    imem[7] = 12'b101_111_110_110;  // ADD   r7 <= r6 + r6

    // Reset held with start high: every output stays zero
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_outputs",
            32'({imem_addr, rf_ra1, rf_ra2, rf_wa, rf_we, rf_wsel, alu_sub, dmem_addr,
                 dmem_we, busy, done, illegal, pc}), 32'd0);
    end
    start   = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("idle_after_reset_busy", 32'(busy), 32'd0);

    // Full run of the 8-instruction program
    run(1'b0, -1);
    check("full_cycles", 32'(run_cyc), 32'd32);
    check("full_pc", 32'(pc), 32'd0);
    check("full_busy", 32'(busy), 32'd0);
    check("full_rf_we_count", 32'(n_we), 32'd7);
    check("full_dmem_we_count", 32'(n_dm), 32'd1);
    check("full_dmem_addr", 32'(last_daddr), 32'd5);
    check("full_no_overlap", 32'(n_both), 32'd0);
    check("full_no_illegal", 32'(n_ill), 32'd0);
    check("r0", 32'(rf[0]), 32'd6);
    check("r1", 32'(rf[1]), 32'd2);
    check("r2", 32'(rf[2]), 32'd8);
    check("r3", 32'(rf[3]), 32'd10);
    check("r4", 32'(rf[4]), 32'd4);
    check("r6", 32'(rf[6]), 32'd2);
    check("r7", 32'(rf[7]), 32'd4);
    check("d5", 32'(dmem[5]), 32'd4);

    // Start pulsed during DECODE of the first instruction is ignored
    run(1'b0, 2);
    check("busy_start_cycles", 32'(run_cyc), 32'd32);
    check("busy_start_done_count", 32'(n_done), 32'd1);
    check("busy_start_pc", 32'(pc), 32'd0);
    repeat (3) @(negedge clk);
    check("busy_start_no_restart", 32'(busy), 32'd0);

    // Step mode: two LOADs bring pc to 2, then the ADD at pc=2
    run(1'b1, -1);
    check("step0_pc", 32'(pc), 32'd1);
    run(1'b1, -1);
    check("step1_pc", 32'(pc), 32'd2);
    run(1'b1, -1);
    check("step2_cycles", 32'(run_cyc), 32'd4);
    check("step2_rf_we_count", 32'(n_we), 32'd1);
    check("step2_wa", 32'(last_wa), 32'd2);
    check("step2_wsel", 32'(last_wsel), 32'd1);
    check("step2_alu_sub", 32'(last_sub), 32'd0);
    check("step2_pc", 32'(pc), 32'd3);
    check("step2_busy", 32'(busy), 32'd0);
    check("step2_r2", 32'(rf[2]), 32'd8);

    // Undefined opcode at pc=3
    imem[3] = 12'b111_000_000_000;
    run(1'b1, -1);
    check("illegal_count", 32'(n_ill), 32'd1);
    check("illegal_in_exec", 32'(ill_cyc), 32'd3);
    check("illegal_rf_we", 32'(n_we), 32'd0);
    check("illegal_dmem_we", 32'(n_dm), 32'd0);
    check("illegal_pc", 32'(pc), 32'd4);
    imem[3] = 12'b101_011_001_010;

    // SUB at pc=4 brings pc to the STORE
    run(1'b1, -1);
    check("sub_alu_sub", 32'(last_sub), 32'd1);
    check("sub_pc", 32'(pc), 32'd5);

    // Reset as the STORE enters EXEC: no data-memory write ever shows
    n_dm = 0;
    @(negedge clk);
    step_mode = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    step_mode = 1'b0;
    @(negedge clk);
    if (dmem_we) n_dm++;
    @(posedge clk);
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (dmem_we) n_dm++;
    end
    check("midop_dmem_we", 32'(n_dm), 32'd0);
    check("midop_pc", 32'(pc), 32'd0);
    check("midop_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("midop_idle_after_release", 32'(busy), 32'd0);
    $display("[TB] reset mid-op pc=%0d busy=%0d", pc, busy);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
